// File: rtl/rempty_ctrl.sv
// rempty_ctrl - read-side pointer / empty-flag controller for the dual-clock FIFO.
//
// Runs entirely in r_clk. It consumes the write Gray pointer after the 2-flop
// synchronizer and produces the outputs listed below.
//
// Ports:
//   r_clk         read-domain clock
//   rst           asynchronous, active-high reset
//   rd_rq         read request; a pop is accepted only while empty=0
//   rsync_ptr2    write Gray pointer, synchronized into r_clk (AW+1 bits)
//   raddr         RAM read address (low AW bits of the binary read pointer)
//   rptr          registered Gray read pointer for the write-domain synchronizer
//   empty         registered empty flag
//   almost_empty  registered; set when the fill level is <= AE_THRESH
//   rd_count      registered, conservative fill level, range 0..DEPTH
//   rd_underflow  sticky read-on-empty flag (only when RD_UNDERFLOW_EN is defined)
//
// Build option:
//   RD_UNDERFLOW_EN  adds the rd_underflow port and its logic. When it is not
//                    defined, reads on empty are silently dropped.
module rempty_ctrl #(
    parameter int WIDTH     = 8,   // carried for consistency with the FIFO; unused here
    parameter int DEPTH     = 16,  // power of 2, >= 4
    parameter int AE_THRESH = 2,   // 0..DEPTH-1
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic          r_clk,
    input  logic          rst,
    input  logic          rd_rq,
    input  logic [AW:0]   rsync_ptr2,
    output logic [AW-1:0] raddr,
    output logic [AW:0]   rptr,
    output logic          empty,
    output logic          almost_empty,
`ifdef RD_UNDERFLOW_EN
    output logic          rd_underflow,
`endif
    output logic [AW:0]   rd_count
);

    localparam int PW = AW + 1;

    logic [AW:0] rbin;
    logic [AW:0] rbinnext;
    logic [AW:0] rgraynext;
    logic [AW:0] wbin_s;
    logic [AW:0] fill_next;
    logic        pop;

    assign pop       = rd_rq & ~empty;
    assign rbinnext  = rbin + PW'(pop);
    assign rgraynext = rbinnext ^ (rbinnext >> 1);
    assign raddr     = rbin[AW-1:0];

    // Gray -> binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        wbin_s     = '0;
        wbin_s[AW] = rsync_ptr2[AW];
        for (int i = AW - 1; i >= 0; i--) begin
            wbin_s[i] = wbin_s[i+1] ^ rsync_ptr2[i];
        end
    end

    // Modulo-2^(AW+1) difference. Because the synchronized write pointer lags the
    // real one, this never exceeds true occupancy. MSB differing with equal low bits
    // yields DEPTH (full).
    assign fill_next = wbin_s - rbinnext;

    always_ff @(posedge r_clk or posedge rst) begin
        if (rst) begin
            rbin         <= '0;
            rptr         <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rd_count     <= '0;
        end else begin
            rbin         <= rbinnext;
            rptr         <= rgraynext;
            // Gray equality. This is equivalent to fill_next == 0, so empty and
            // rd_count always agree.
            empty        <= (rgraynext == rsync_ptr2);
            almost_empty <= (fill_next <= PW'(AE_THRESH));
            rd_count     <= fill_next;
        end
    end

`ifdef RD_UNDERFLOW_EN
    always_ff @(posedge r_clk or posedge rst) begin
        if (rst)
            rd_underflow <= 1'b0;
        else if (rd_rq & empty)
            rd_underflow <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_rempty_ctrl.sv
// Self-checking bench for rempty_ctrl (DEPTH=16, AE_THRESH=2).
//
// Each step drives inputs on the falling edge and predicts the post-edge outputs
// from an integer occupancy model. The prediction is pushed to a queue, then popped
// and compared #1 after the rising edge.
module tb_rempty_ctrl;

    localparam int DEPTH = 16;
    localparam int AE    = 2;
    localparam int AW    = 4;

    logic          r_clk = 1'b0;
    logic          rst   = 1'b1;
    logic          rd_rq = 1'b0;
    logic [AW:0]   rsync_ptr2 = '0;
    logic [AW-1:0] raddr;
    logic [AW:0]   rptr;
    logic          empty;
    logic          almost_empty;
    logic [AW:0]   rd_count;
    logic          uf_obs;

`ifdef RD_UNDERFLOW_EN
    logic rd_underflow;
    assign uf_obs = rd_underflow;
`else
    assign uf_obs = 1'b0;
`endif

    rempty_ctrl #(.WIDTH(8), .DEPTH(DEPTH), .AE_THRESH(AE)) dut (
        .r_clk        (r_clk),
        .rst          (rst),
        .rd_rq        (rd_rq),
        .rsync_ptr2   (rsync_ptr2),
        .raddr        (raddr),
        .rptr         (rptr),
        .empty        (empty),
        .almost_empty (almost_empty),
`ifdef RD_UNDERFLOW_EN
        .rd_underflow (rd_underflow),
`endif
        .rd_count     (rd_count)
    );

    always #5 r_clk = ~r_clk;

    typedef struct packed {
        logic [AW:0]   rptr;
        logic [AW-1:0] raddr;
        logic          empty;
        logic          ae;
        logic [AW:0]   cnt;
        logic          uf;
    } exp_t;

    exp_t        sb_q[$];
    int          n_run  = 0;
    int          n_fail = 0;

    // Reference state: binary read count, write count, sticky underflow.
    logic [AW:0] m_rbin;
    logic [AW:0] m_wcnt;
    logic        m_empty;
    logic        m_uf;

    function automatic logic [AW:0] gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge r_clk);
        rst = 1'b1;
        rd_rq = 1'b1;            // reset must win regardless of rd_rq
        #1;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_ae",    32'(almost_empty), 32'd1);
        chk("rst_rptr",  32'(rptr), 32'd0);
        chk("rst_raddr", 32'(raddr), 32'd0);
        chk("rst_cnt",   32'(rd_count), 32'd0);
        chk("rst_uf",    32'(uf_obs), 32'd0);
        @(negedge r_clk);
        rst = 1'b0;
        rd_rq = 1'b0;
        rsync_ptr2 = '0;
        m_rbin = '0; m_wcnt = '0; m_empty = 1'b1; m_uf = 1'b0;
        sb_q.delete();
    endtask

    // One clock: drive at negedge, predict, compare after posedge.
    task automatic step(input logic rq, input logic [AW:0] wc, input string tag);
        exp_t e, g;
        logic pop;
        logic [AW:0] nb, cnt;
        rd_rq = rq;
        m_wcnt = wc;
        rsync_ptr2 = gray(wc);
        pop = rq & ~m_empty;
        nb  = m_rbin + (AW+1)'(pop);
        cnt = wc - nb;
`ifdef RD_UNDERFLOW_EN
        if (rq & m_empty) m_uf = 1'b1;
`endif
        e.rptr  = gray(nb);
        e.raddr = nb[AW-1:0];
        e.empty = (cnt == 0);
        e.ae    = (int'(cnt) <= AE);
        e.cnt   = cnt;
        e.uf    = m_uf;
        sb_q.push_back(e);
        m_rbin  = nb;
        m_empty = e.empty;
        @(posedge r_clk);
        #1;
        g = sb_q.pop_front();
        chk({tag, ".rptr"},  32'(rptr), 32'(g.rptr));
        chk({tag, ".raddr"}, 32'(raddr), 32'(g.raddr));
        chk({tag, ".empty"}, 32'(empty), 32'(g.empty));
        chk({tag, ".ae"},    32'(almost_empty), 32'(g.ae));
        chk({tag, ".cnt"},   32'(rd_count), 32'(g.cnt));
        chk({tag, ".uf"},    32'(uf_obs), 32'(g.uf));
        @(negedge r_clk);
    endtask

    initial begin
        logic [AW:0] w;
        m_rbin = '0; m_wcnt = '0; m_empty = 1'b1; m_uf = 1'b0;
        #12;
        do_reset();

        // Write pointer arrives at 3, then drain: count 3 -> 2 -> 1 -> 0.
        step(1'b0, 5'd3, "arrive");
        chk("arrive_cnt_const", 32'(rd_count), 32'd3);
        for (int i = 0; i < 3; i++) step(1'b1, 5'd3, "drain");
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_raddr", 32'(raddr), 32'd3);

        // Reset mid-operation with non-zero pointers.
        do_reset();

        // Wrap: write pointer one ahead, 20 pops (pop and write in the same cycle).
        step(1'b0, 5'd1, "wrap_pre");
        for (int i = 0; i < 20; i++) begin
            w = (i + 2 > 20) ? 5'd20 : 5'(i + 2);
            step(1'b1, w, "wrap");
            if (i == 15) begin
                chk("wrap16_rptr",  32'(rptr), 32'b11000);
                chk("wrap16_raddr", 32'(raddr), 32'd0);
            end
        end
        chk("wrap20_raddr", 32'(raddr), 32'd4);
        chk("wrap20_empty", 32'(empty), 32'd1);

        // Full level: write pointer DEPTH ahead of read pointer 0.
        do_reset();
        step(1'b0, 5'd16, "full");
        chk("full_cnt_const", 32'(rd_count), 32'd16);
        step(1'b1, 5'd16, "full_pop");

        // Read on empty: pointers must hold; underflow sticks until reset.
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 5'd0, "rd_empty");
        step(1'b0, 5'd0, "rd_empty_hold");
        step(1'b0, 5'd2, "after_uf");
        do_reset();

        // Random mix against the model (bounded: write never exceeds DEPTH ahead).
        for (int i = 0; i < 200; i++) begin
            w = m_wcnt;
            if ($urandom_range(0, 1) == 1 && 5'(w - m_rbin) < 5'(DEPTH)) w = w + 5'd1;
            step(1'($urandom_range(0, 1)), w, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
